// File: rtl/dispatcher.sv
// One-to-many valid/stall router: each upstream item is steered to a per-port 2-entry FIFO.
// Optional broadcast (bcast_us port) enabled by defining DISPATCH_BCAST_EN.
module dispatcher #(
    parameter int NUM_OUT = 4,
    parameter int WIDTH   = 10,
    parameter int DEST_W  = $clog2(NUM_OUT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_us,
    input  logic [DEST_W-1:0]               dest_us,
    input  logic [WIDTH-1:0]                data_us,
`ifdef DISPATCH_BCAST_EN
    input  logic                            bcast_us,
`endif
    output logic                            stall_us,
    output logic [NUM_OUT-1:0]              valid_ds,
    output logic [NUM_OUT-1:0][WIDTH-1:0]   data_ds,
    input  logic [NUM_OUT-1:0]              stall_ds,
    output logic                            drop_err
);

    logic [NUM_OUT-1:0][1:0][WIDTH-1:0] mem_q, mem_d;
    logic [NUM_OUT-1:0][1:0]            cnt_q, cnt_d;
    logic [NUM_OUT-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [NUM_OUT-1:0]                 wr_ptr_q, wr_ptr_d;
    logic                               drop_q, drop_d;

    logic                               bcast_sel;
    logic                               in_range;
    logic                               full_dest;
    logic                               full_any;
    logic                               accept;
    logic [NUM_OUT-1:0]                 push;
    logic [NUM_OUT-1:0]                 pop;

`ifdef DISPATCH_BCAST_EN
    assign bcast_sel = bcast_us;
`else
    assign bcast_sel = 1'b0;
`endif

    // Widened compare so the range check stays meaningful when NUM_OUT is a power of 2.
    assign in_range = ({1'b0, dest_us} < (DEST_W+1)'(NUM_OUT));

    always_comb begin
        full_dest = 1'b0;
        full_any  = 1'b0;
        for (int p = 0; p < NUM_OUT; p++) begin
            if (cnt_q[p] == 2'd2) begin
                full_any = 1'b1;
                if (dest_us == DEST_W'(p)) full_dest = 1'b1;
            end
        end
    end

    // Stall depends only on registered occupancy, never on stall_ds.
    always_comb begin
        if (bcast_sel) stall_us = valid_us & full_any;
        else           stall_us = valid_us & in_range & full_dest;
    end

    assign accept = valid_us & ~stall_us;
    assign drop_d = accept & ~bcast_sel & ~in_range;

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = '0;
        pop      = '0;
        for (int p = 0; p < NUM_OUT; p++) begin
            pop[p]  = (cnt_q[p] != 2'd0) & ~stall_ds[p];
            push[p] = accept & (bcast_sel | (in_range & (dest_us == DEST_W'(p))));
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = data_us;
                wr_ptr_d[p]           = ~wr_ptr_q[p];
            end
            if (pop[p]) rd_ptr_d[p] = ~rd_ptr_q[p];
            case ({push[p], pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + 2'd1;
                2'b01:   cnt_d[p] = cnt_q[p] - 2'd1;
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    always_comb begin
        valid_ds = '0;
        data_ds  = '0;
        for (int p = 0; p < NUM_OUT; p++) begin
            valid_ds[p] = (cnt_q[p] != 2'd0);
            if (valid_ds[p]) data_ds[p] = mem_q[p][rd_ptr_q[p]];
        end
    end

    assign drop_err = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: queue-based reference model, directed and random traffic.
module tb_dispatcher;

    localparam int N = 4;
    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_us;
    logic [1:0]          dest_us;
    logic [W-1:0]        data_us;
    logic                bcast;
    logic                stall_us;
    logic [N-1:0]        valid_ds;
    logic [N-1:0][W-1:0] data_ds;
    logic [N-1:0]        stall_ds;
    logic                drop_err;

    logic                v3;
    logic [1:0]          d3;
    logic [W-1:0]        dat3;
    logic                bc3;
    logic                stall3;
    logic [2:0]          valid3;
    logic [2:0][W-1:0]   data3;
    logic [2:0]          sds3;
    logic                drop3;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] q [N][$];

    always #5 clk = ~clk;

    dispatcher #(.NUM_OUT(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid_us(valid_us), .dest_us(dest_us), .data_us(data_us),
`ifdef DISPATCH_BCAST_EN
        .bcast_us(bcast),
`endif
        .stall_us(stall_us), .valid_ds(valid_ds), .data_ds(data_ds),
        .stall_ds(stall_ds), .drop_err(drop_err)
    );

    dispatcher #(.NUM_OUT(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst(rst), .valid_us(v3), .dest_us(d3), .data_us(dat3),
`ifdef DISPATCH_BCAST_EN
        .bcast_us(bc3),
`endif
        .stall_us(stall3), .valid_ds(valid3), .data_ds(data3),
        .stall_ds(sds3), .drop_err(drop3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the queue model, then advance the model.
    task automatic cycle(input logic v, input logic [1:0] d, input logic [W-1:0] dat,
                         input logic [N-1:0] sds, input logic bc);
        logic         exp_stall;
        logic [N-1:0] exp_v;
        logic [W-1:0] exp_d;
        @(negedge clk);
        valid_us = v; dest_us = d; data_us = dat; stall_ds = sds; bcast = bc;
        #1;
        if (v && bc) begin
            exp_stall = 1'b0;
            for (int p = 0; p < N; p++) if (q[p].size() == 2) exp_stall = 1'b1;
        end else begin
            exp_stall = v && (q[d].size() == 2);
        end
        for (int p = 0; p < N; p++) exp_v[p] = (q[p].size() != 0);
        chk("stall_us", 32'(stall_us), 32'(exp_stall));
        chk("valid_ds", 32'(valid_ds), 32'(exp_v));
        for (int p = 0; p < N; p++) begin
            exp_d = (q[p].size() != 0) ? q[p][0] : '0;
            chk($sformatf("data_ds[%0d]", p), 32'(data_ds[p]), 32'(exp_d));
        end
        chk("drop_err", 32'(drop_err), 32'd0);
        for (int p = 0; p < N; p++)
            if (q[p].size() != 0 && !sds[p]) void'(q[p].pop_front());
        if (v && !exp_stall) begin
            if (bc) begin
                for (int p = 0; p < N; p++) q[p].push_back(dat);
            end else begin
                q[d].push_back(dat);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_us = 1'b0; dest_us = '0; data_us = '0; stall_ds = '0; bcast = 1'b0;
        v3 = 1'b0; d3 = '0; dat3 = '0; sds3 = '0; bc3 = 1'b0;
        #2;
        chk("rst valid_ds", 32'(valid_ds), 32'd0);
        chk("rst data_ds", 32'(data_ds), 32'd0);
        chk("rst stall_us", 32'(stall_us), 32'd0);
        chk("rst drop_err", 32'(drop_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single item to port 2
        cycle(1'b1, 2'd2, 10'h155, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);
        chk("t1 valid_ds", 32'(valid_ds), 32'b0100);
        chk("t1 data_ds2", 32'(data_ds[2]), 32'h155);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);

        // port 1 stalled: A, B absorbed, C held, then release
        cycle(1'b1, 2'd1, 10'h0A1, 4'b0010, 1'b0);
        cycle(1'b1, 2'd1, 10'h0B2, 4'b0010, 1'b0);
        cycle(1'b1, 2'd1, 10'h0C3, 4'b0010, 1'b0);
        chk("t2 C stalled", 32'(stall_us), 32'd1);
        cycle(1'b1, 2'd1, 10'h0C3, 4'b0000, 1'b0);
        chk("t2 unstall edge", 32'(data_ds[1]), 32'h0A1);
        cycle(1'b1, 2'd1, 10'h0C3, 4'b0000, 1'b0);
        chk("t2 C accepted", 32'(stall_us), 32'd0);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);

        // port 1 full and stalled, alternate port 1 / port 3
        cycle(1'b1, 2'd1, 10'h011, 4'b0010, 1'b0);
        cycle(1'b1, 2'd1, 10'h012, 4'b0010, 1'b0);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, (i % 2 == 0) ? 2'd1 : 2'd3, 10'(10'h100 + i), 4'b0010, 1'b0);

        // asynchronous reset with items buffered
        @(negedge clk);
        valid_us = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst valid_ds", 32'(valid_ds), 32'd0);
        chk("midrst data_ds", 32'(data_ds), 32'd0);
        for (int p = 0; p < N; p++) q[p].delete();
        @(negedge clk);
        rst = 1'b0;

        // port 0 steady at one entry: push and pop every cycle
        cycle(1'b1, 2'd0, 10'h200, 4'b0000, 1'b0);
        for (int i = 1; i <= 10; i++)
            cycle(1'b1, 2'd0, 10'(10'h200 + i), 4'b0000, 1'b0);
        chk("t5 one entry", 32'(valid_ds), 32'b0001);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);

`ifdef DISPATCH_BCAST_EN
        cycle(1'b1, 2'd1, 10'h3FF, 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);
        chk("bc valid_ds", 32'(valid_ds), 32'b1111);
        chk("bc data_ds", 32'(data_ds), {4{10'h3FF}});
        cycle(1'b1, 2'd2, 10'h021, 4'b0100, 1'b0);
        cycle(1'b1, 2'd2, 10'h022, 4'b0100, 1'b0);
        cycle(1'b1, 2'd0, 10'h0EE, 4'b0100, 1'b1);
        chk("bc stalled", 32'(stall_us), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, 10'h0EE, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 10'h000, 4'b0000, 1'b0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] sds;
            sds = '0;
            for (int p = 0; p < N; p++) sds[p] = ($urandom_range(0, 99) < 40);
`ifdef DISPATCH_BCAST_EN
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 10'($urandom), sds,
                  1'($urandom_range(0, 9) == 0));
`else
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 10'($urandom), sds, 1'b0);
`endif
        end

        // three-port instance: out-of-range destination is dropped
        @(negedge clk);
        valid_us = 1'b0;
        v3 = 1'b1; d3 = 2'd3; dat3 = 10'h0AA;
        #1;
        chk("n3 drop stall_us", 32'(stall3), 32'd0);
        chk("n3 drop_err pre", 32'(drop3), 32'd0);
        @(negedge clk);
        v3 = 1'b0;
        #1;
        chk("n3 drop_err", 32'(drop3), 32'd1);
        chk("n3 valid_ds", 32'(valid3), 32'd0);
        @(negedge clk);
        #1;
        chk("n3 drop_err end", 32'(drop3), 32'd0);
        v3 = 1'b1; d3 = 2'd1; dat3 = 10'h005;
        @(negedge clk);
        v3 = 1'b0;
        #1;
        chk("n3 inrange drop", 32'(drop3), 32'd0);
        chk("n3 inrange valid", 32'(valid3), 32'b010);
        chk("n3 inrange data", 32'(data3[1]), 32'h005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
# dispatcher

One-to-many valid/stall router that sits opposite the round-robin arbiter. It takes a single upstream stream and steers each item to one of NUM_OUT downstream ports selected by a per-item destination index. Each downstream port has its own 2-entry FIFO, so a stalled port never blocks traffic bound for other ports unless the stalled port's FIFO is the current item's target. It is used to fan ray/work packets out from a shared pipeline stage to per-unit queues.

## Interface
Parameters:
- NUM_OUT, 4: number of downstream ports, ≥2.
- WIDTH, 10: payload width.
- DEST_W, $clog2(NUM_OUT): destination index width.

Ports:
- clk  input  1  clock; one clock domain only.
- rst  input  1  asynchronous, active-high reset.
- valid_us  input  1  upstream item present.
- dest_us  input  DEST_W  destination port index of the upstream item.
- data_us  input  WIDTH  upstream payload.
- stall_us  output  1  upstream must hold its item this cycle.
- valid_ds  output  NUM_OUT  per-port item present.
- data_ds  output  NUM_OUT×WIDTH  per-port payload, packed [NUM_OUT-1:0][WIDTH-1:0].
- stall_ds  input  NUM_OUT  per-port downstream stall.
- drop_err  output  1  one-cycle pulse when an item with an out-of-range destination is discarded.
- bcast_us  input  1  broadcast request. Present only with DISPATCH_BCAST_EN.

## Operation
- Each port p has a 2-entry FIFO with a registered occupancy cnt[p] in 0..2, a read pointer and a write pointer.
- Upstream accept condition: valid_us & ~stall_us.
- stall_us = valid_us & (dest_us < NUM_OUT) & (cnt[dest_us] == 2).
  - stall_us is a function of registered cnt only, so there is no combinational path from stall_ds to stall_us.
- On accept with dest_us < NUM_OUT: write data_us into FIFO[dest_us] at the clock edge.
- On accept with dest_us ≥ NUM_OUT (possible only when NUM_OUT is not a power of 2):
  - item is consumed (stall_us = 0) and discarded;
  - drop_err is asserted for the following cycle;
  - no FIFO changes.
- Downstream per port:
  - valid_ds[p] = (cnt[p] != 0).
  - data_ds[p] = FIFO head when valid, else 0.
  - Transfer occurs on valid_ds[p] & ~stall_ds[p], which pops the head at the edge.
  - stall_ds[p] while valid_ds[p] = 0 is ignored.
- Occupancy update per port:
  - push only: +1;
  - pop only: -1;
  - push and pop in the same cycle: unchanged.
  - Simultaneous push and pop is legal at cnt = 1. At cnt = 2 push is blocked; a pop still occurs and the item stays stalled one cycle.
- Pointers are 1 bit and wrap 1→0.
- Order is preserved per port. Across ports there is no ordering guarantee.
- Reset: all cnt = 0, all pointers = 0, FIFO storage = 0, valid_ds = 0, data_ds = 0, drop_err = 0, stall_us = 0.
- Reset asserted mid-operation discards all buffered items immediately (asynchronous).

## Timing
- Latency: an item accepted at edge N appears on valid_ds/data_ds after edge N, i.e. in cycle N+1, provided its FIFO was empty.
- Throughput: 1 item/cycle sustained into any port whose downstream never stalls.
- A port stalled for k cycles absorbs 2 items, then stall_us rises for items targeting it.
- Unstall recovery: the cycle after stall_ds[p] falls, the head pops. cnt[p] drops from 2 to 1 at that edge, and stall_us falls the next cycle.
- drop_err is registered: high exactly in the cycle after the discarding accept.
- All outputs except stall_us are registered. stall_us is combinational from valid_us, dest_us and cnt.

## Configuration
- DISPATCH_BCAST_EN defined:
  - bcast_us port exists.
  - When valid_us & bcast_us: stall_us = valid_us & (any cnt[p] == 2); dest_us is ignored.
  - On accept, data_us is pushed into every port's FIFO in the same edge.
  - Broadcast never raises drop_err.
- DISPATCH_BCAST_EN undefined: no bcast_us port; unicast only, as described above.

## Test plan
- Reset, then valid_us = 1, dest_us = 2, data_us = 0x155 for 1 cycle → valid_ds = 4'b0100 and data_ds[2] = 0x155 next cycle; stall_us stays 0.
- stall_ds[1] = 1 held; 3 back-to-back items A, B, C to port 1 → A and B accepted; stall_us = 1 while C is presented. Release stall_ds[1] → A, B, C delivered in order on consecutive cycles after unstall.
- Port 1 full and stalled; alternate items to ports 1 and 3 → stall_us is high only on port-1 items; port 3 receives every offered item with 1-cycle latency.
- NUM_OUT = 3, dest_us = 3, data 0x0AA → stall_us = 0; drop_err = 1 for exactly one cycle; valid_ds stays 0.
- Port 0 at cnt = 1 with push and pop in the same cycle for 10 cycles → cnt stays 1, 1 item/cycle out, no stall_us.
- DISPATCH_BCAST_EN defined, bcast_us = 1, data 0x3FF → all 4 valid_ds high next cycle with data 0x3FF. With port 2 full, the broadcast stalls until port 2 pops.
